// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for a two-phase (FETCH/EXEC) CPU
// with one branch delay slot.
//
// Every unstalled EXEC edge latches three candidate jump targets from the
// current instruction. These are relative, page-absolute and register-absolute.
// The branch decision logic judges the branch at the end of its EXEC.
// Its selection therefore arrives during the following EXEC, the delay slot.
// That selection picks one of the candidates latched one EXEC earlier.
// A next pc of 0x00000000 halts the sequencer.
//
// Optional feature: define PC_ALIGN_CHECK_EN to halt with a fault when a
// selected jump target is not word aligned. The pc stays unchanged in that case.
module pc_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  jump_addr_selection,
    input  logic [31:0] instruction_word,
    input  logic [31:0] rs_data,
    output logic [31:0] pc,
    output logic        state,
    output logic [31:0] link_addr,
    output logic        active,
    output logic        fault
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_rel;
    logic [31:0] r_page;
    logic [31:0] r_abs;
    logic        r_active;
    logic        r_fault;

    state_t      w_state_next;
    logic [31:0] w_pc_next;
    logic [31:0] w_rel_next;
    logic [31:0] w_page_next;
    logic [31:0] w_abs_next;
    logic        w_active_next;
    logic        w_fault_next;

    logic [31:0] w_seq_pc;
    logic [31:0] w_imm_ext;
    logic [31:0] w_rel_cand;
    logic [31:0] w_page_cand;
    logic [31:0] w_target;
    logic        w_misaligned;
    logic        w_unused_opcode;

    // The opcode field is decoded elsewhere; this sequencer never needs it.
    assign w_unused_opcode = &{1'b0, instruction_word[31:26]};

    // Candidate targets from the instruction now in EXEC, plus selection of the next pc.
    always_comb begin
        w_seq_pc    = r_pc + 32'd4;
        w_imm_ext   = {{14{instruction_word[15]}}, instruction_word[15:0], 2'b00};
        w_rel_cand  = w_seq_pc + w_imm_ext;
        w_page_cand = {w_seq_pc[31:28], instruction_word[25:0], 2'b00};
        case (jump_addr_selection)
            2'b00:   w_target = w_seq_pc;
            2'b01:   w_target = r_abs;
            2'b10:   w_target = r_page;
            2'b11:   w_target = r_rel;
            default: w_target = w_seq_pc;
        endcase
`ifdef PC_ALIGN_CHECK_EN
        if ((jump_addr_selection != 2'b00) && (w_target[1:0] != 2'b00)) begin
            w_misaligned = 1'b1;
        end else begin
            w_misaligned = 1'b0;
        end
`else
        w_misaligned = 1'b0;
`endif
    end

    // Next-state and next-register values; stall or HALT simply hold everything.
    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_rel_next    = r_rel;
        w_page_next   = r_page;
        w_abs_next    = r_abs;
        w_active_next = r_active;
        w_fault_next  = r_fault;
        if (!stall) begin
            case (r_state)
                ST_FETCH: begin
                    w_state_next = ST_EXEC;
                end
                ST_EXEC: begin
                    // Candidates are always refreshed; the selection above used the old ones.
                    w_rel_next  = w_rel_cand;
                    w_page_next = w_page_cand;
                    w_abs_next  = rs_data;
                    if (w_misaligned) begin
                        w_state_next  = ST_HALT;
                        w_fault_next  = 1'b1;
                        w_active_next = 1'b0;
                    end else if (w_target == 32'h0000_0000) begin
                        w_state_next  = ST_HALT;
                        w_pc_next     = 32'h0000_0000;
                        w_active_next = 1'b0;
                    end else begin
                        w_state_next  = ST_FETCH;
                        w_pc_next     = w_target;
                    end
                end
                ST_HALT: begin
                    w_state_next = ST_HALT;
                end
                default: begin
                    w_state_next  = ST_HALT;
                    w_active_next = 1'b0;
                end
            endcase
        end else begin
            w_state_next = r_state;
        end
    end

    // State and datapath registers with asynchronous reset to the boot vector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_FETCH;
            r_pc     <= RESET_PC;
            r_rel    <= 32'h0000_0000;
            r_page   <= 32'h0000_0000;
            r_abs    <= 32'h0000_0000;
            r_active <= 1'b1;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            r_rel    <= w_rel_next;
            r_page   <= w_page_next;
            r_abs    <= w_abs_next;
            r_active <= w_active_next;
            r_fault  <= w_fault_next;
        end
    end

    assign pc        = r_pc;
    assign state     = (r_state == ST_EXEC);
    assign link_addr = r_pc + 32'd8;
    assign active    = r_active;
`ifdef PC_ALIGN_CHECK_EN
    assign fault     = r_fault;
`else
    assign fault     = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a directed vector table plus
// hand-written sequences for reset, stall, wrap-around and alignment cases.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [1:0]  jump_addr_selection;
    logic [31:0] instruction_word;
    logic [31:0] rs_data;
    logic [31:0] pc;
    logic        state;
    logic [31:0] link_addr;
    logic        active;
    logic        fault;

    int n_tests;
    int n_fail;

    pc_sequencer dut (
        .clk                 (clk),
        .reset               (reset),
        .stall               (stall),
        .jump_addr_selection (jump_addr_selection),
        .instruction_word    (instruction_word),
        .rs_data             (rs_data),
        .pc                  (pc),
        .state               (state),
        .link_addr           (link_addr),
        .active              (active),
        .fault               (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stl;
        logic [1:0]  sel;
        logic [31:0] iw;
        logic [31:0] rs;
        logic [31:0] exp_pc;
        logic        exp_state;
        logic        exp_active;
    } vec_t;

    vec_t vecs [20];

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic expect_all(input string nm, input logic [31:0] p, input logic st,
                              input logic act, input logic flt);
        check32({nm, ".pc"}, pc, p);
        check32({nm, ".state"}, {31'd0, state}, {31'd0, st});
        check32({nm, ".active"}, {31'd0, active}, {31'd0, act});
        check32({nm, ".fault"}, {31'd0, fault}, {31'd0, flt});
        check32({nm, ".link"}, link_addr, p + 32'd8);
    endtask

    // Apply one cycle of inputs, then sample just after the rising edge.
    task automatic cyc(input logic s, input logic [1:0] sl, input logic [31:0] iw, input logic [31:0] rs);
        stall               = s;
        jump_addr_selection = sl;
        instruction_word    = iw;
        rs_data             = rs;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse between clock edges, checked before any edge.
    task automatic reset_pulse(input string nm);
        reset = 1'b1;
        #1;
        expect_all(nm, 32'hBFC0_0000, 1'b0, 1'b1, 1'b0);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        stall = 1'b0;
        jump_addr_selection = 2'b00;
        instruction_word = 32'h0;
        rs_data = 32'h0;

        //            stall sel    instr          rs            exp_pc        st    act
        vecs[0]  = '{1'b0, 2'b00, 32'h0000_0000, 32'h0,        32'hBFC0_0000, 1'b1, 1'b1};
        vecs[1]  = '{1'b0, 2'b00, 32'h1000_0004, 32'h0,        32'hBFC0_0004, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 2'b11, 32'h0000_0000, 32'h0,        32'hBFC0_0004, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 2'b11, 32'h0000_0000, 32'h0,        32'hBFC0_0014, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 2'b00, 32'h0000_0000, 32'h0,        32'hBFC0_0014, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 2'b00, 32'h0800_0100, 32'h0,        32'hBFC0_0018, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 2'b00, 32'h0000_0000, 32'h0,        32'hBFC0_0018, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 2'b10, 32'h1000_0001, 32'h1234,     32'hBFC0_0018, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 2'b10, 32'h1000_0001, 32'h1234,     32'hBFC0_0018, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 2'b10, 32'h0000_0000, 32'h0,        32'hB000_0400, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 2'b00, 32'h0000_0000, 32'h0,        32'hB000_0400, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 2'b00, 32'h1000_FFFF, 32'h0,        32'hB000_0404, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 2'b00, 32'h0000_0000, 32'h0,        32'hB000_0404, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 2'b11, 32'h0000_0000, 32'h0,        32'hB000_0400, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 2'b00, 32'h0000_0000, 32'h0,        32'hB000_0400, 1'b1, 1'b1};
        vecs[15] = '{1'b0, 2'b00, 32'h0000_0008, 32'h0,        32'hB000_0404, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 2'b00, 32'h0000_0000, 32'h0,        32'hB000_0404, 1'b1, 1'b1};
        vecs[17] = '{1'b0, 2'b01, 32'h0000_0000, 32'h0,        32'h0000_0000, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 2'b01, 32'h0000_0000, 32'h0,        32'h0000_0000, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 2'b00, 32'h0000_0000, 32'h5555,     32'h0000_0000, 1'b0, 1'b0};

        #2;
        expect_all("reset", 32'hBFC0_0000, 1'b0, 1'b1, 1'b0);
        #10;
        reset = 1'b0;

        // Table-driven run: sequential flow, delay slots, J, negative branch, JR to 0.
        for (int i = 0; i < 20; i++) begin
            cyc(vecs[i].stl, vecs[i].sel, vecs[i].iw, vecs[i].rs);
            expect_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_state,
                       vecs[i].exp_active, 1'b0);
        end

        // Reset out of HALT.
        reset_pulse("rst_halt");

        // A pending branch target must not survive reset: candidates read back as 0.
        cyc(1'b0, 2'b00, 32'h0, 32'h0);
        cyc(1'b0, 2'b00, 32'h1000_0004, 32'h0);
        reset_pulse("rst_slot");
        cyc(1'b0, 2'b11, 32'h0, 32'h0);
        cyc(1'b0, 2'b11, 32'h0, 32'h0);
        expect_all("discard", 32'h0000_0000, 1'b0, 1'b0, 1'b0);

        // Five stalled cycles in EXEC, then one advance; then reset during stall.
        reset_pulse("rst_stall0");
        cyc(1'b0, 2'b00, 32'h0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 2'b00, 32'h0, 32'h0);
            expect_all($sformatf("stall%0d", k), 32'hBFC0_0000, 1'b1, 1'b1, 1'b0);
        end
        cyc(1'b0, 2'b00, 32'h0, 32'h0);
        expect_all("unstall", 32'hBFC0_0004, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 2'b00, 32'h0, 32'h0);
        cyc(1'b1, 2'b00, 32'h0, 32'h0);
        expect_all("stall_hold", 32'hBFC0_0004, 1'b1, 1'b1, 1'b0);
        reset_pulse("rst_in_stall");

        // Wrap: JR to 0xFFFFFFFC, then sequential +4 wraps to 0 and halts.
        cyc(1'b0, 2'b00, 32'h0, 32'h0);
        cyc(1'b0, 2'b00, 32'h0000_0008, 32'hFFFF_FFFC);
        cyc(1'b0, 2'b00, 32'h0, 32'h0);
        cyc(1'b0, 2'b01, 32'h0, 32'h0);
        expect_all("wrap_top", 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 2'b00, 32'h0, 32'h0);
        cyc(1'b0, 2'b00, 32'h0, 32'h0);
        expect_all("wrap_halt", 32'h0000_0000, 1'b0, 1'b0, 1'b0);

        // JR to a misaligned address.
        reset_pulse("rst_align");
        cyc(1'b0, 2'b00, 32'h0, 32'h0);
        cyc(1'b0, 2'b00, 32'h0000_0008, 32'hBFC0_0102);
        cyc(1'b0, 2'b00, 32'h0, 32'h0);
        cyc(1'b0, 2'b01, 32'h0, 32'h0);
`ifdef PC_ALIGN_CHECK_EN
        expect_all("align", 32'hBFC0_0004, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 2'b00, 32'h0, 32'h0);
        expect_all("align_hold", 32'hBFC0_0004, 1'b0, 1'b0, 1'b1);
`else
        expect_all("align", 32'hBFC0_0102, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 2'b00, 32'h0, 32'h0);
        expect_all("align_next", 32'hBFC0_0102, 1'b1, 1'b1, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on posedge clk.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port stall, input, 1, memory wait; high freezes all registers and FSM for that cycle.
REQ-004 SHALL have port jump_addr_selection, input, 2: 00 none, 01 absolute (rs), 10 page-absolute, 11 PC-relative; registered by the branch decision logic at end of the branch's EXEC.
REQ-005 SHALL have port instruction_word, input, 32, instruction currently in EXEC.
REQ-006 SHALL have port rs_data, input, 32, register rs value of the instruction in EXEC.
REQ-007 SHALL have port pc, output, 32, address of the instruction being fetched/executed.
REQ-008 SHALL have port state, output, 1: 0 FETCH, 1 EXEC; drives the state input of the branch decision logic.
REQ-009 SHALL have port link_addr, output, 32, pc+8 (combinational from pc register), written back by link instructions.
REQ-010 SHALL have port active, output, 1, high until the CPU halts.
REQ-011 SHALL have port fault, output, 1, misaligned-target flag (see Configuration).

Function
REQ-012 FSM states SHALL be FETCH, EXEC, HALT; FETCH->EXEC, EXEC->FETCH or HALT on each unstalled edge; HALT is terminal until reset.
REQ-013 state output SHALL be 1 only in EXEC; 0 in FETCH and HALT.
REQ-014 At every unstalled EXEC edge the block SHALL latch three candidate targets from the current instruction: rel = pc+4+(sign-extended instruction_word[15:0] << 2); page = {(pc+4)[31:28], instruction_word[25:0], 2'b00}; abs = rs_data.
REQ-015 At every unstalled EXEC edge next pc SHALL be: pc+4 if jump_addr_selection==00, else the candidate (latched at the previous EXEC, i.e. from the branch) selected by jump_addr_selection; candidate overwrite and selection use pre-edge values.
REQ-016 Consequently the instruction after a branch (delay slot) SHALL always execute; the jump takes effect after it, one instruction late, with zero extra cycles.
REQ-017 pc SHALL change only on unstalled EXEC edges; FETCH edges leave pc unchanged.
REQ-018 All address arithmetic SHALL be 32-bit modulo 2^32 (wrap 0xFFFFFFFC+4 = 0x00000000).
REQ-019 If next pc computed per REQ-015 equals 0x00000000, FSM SHALL enter HALT, pc SHALL load 0x00000000, active SHALL fall to 0 on that edge.
REQ-020 A branch in a delay slot SHALL follow REQ-014/015 mechanically: first target taken, second branch's selection applies after the instruction at the first target.
REQ-021 stall high SHALL hold pc, FSM, candidates, active, fault regardless of state.

Reset
REQ-022 reset high SHALL immediately set pc=0xBFC00000, FSM=FETCH, active=1, fault=0, all candidates 0, independent of clk and stall.
REQ-023 reset mid-operation (any state incl. HALT, mid-delay-slot) SHALL discard pending jump targets; first EXEC after reset uses whatever jump_addr_selection is presented (branch logic must also be reset).
REQ-024 link_addr SHALL read 0xBFC00008 during reset.

Configuration
REQ-025 Macro PC_ALIGN_CHECK_EN defined: if selected target has bits[1:0]!=0 at an EXEC edge, FSM SHALL enter HALT, fault=1, active=0, pc unchanged.
REQ-026 PC_ALIGN_CHECK_EN undefined: fault SHALL be constant 0 and targets SHALL be loaded unmodified.

Verification
REQ-027 Reset then 3 unstalled FETCH/EXEC pairs, selection 00 -> pc 0xBFC00000, 0xBFC00004, 0xBFC00008, 0xBFC0000C; state toggles 0,1.
REQ-028 Branch at 0xBFC00000 with imm 0x0004, selection 11 presented during next EXEC -> delay slot at 0xBFC00004 executes, then pc=0xBFC00014.
REQ-029 JR with rs_data=0x00000000 at 0xBFC00010, selection 01 next EXEC -> pc 0xBFC00014 executes, then pc=0, active=0, state stays 0 forever.
REQ-030 J with index 0x0000100 at 0xBFC00020 -> after delay slot pc=0xB0000400; link_addr during J EXEC = 0xBFC00028.
REQ-031 stall held 5 cycles in EXEC then released -> pc/state frozen 5 cycles, then single advance; reset asserted during stall -> pc=0xBFC00000 without clock edge.
REQ-032 PC_ALIGN_CHECK_EN defined, JR rs_data=0xBFC00102 -> fault=1, active=0 after delay slot; undefined -> pc=0xBFC00102, fault=0.
